dualmem_be: RTL and testbench



---
 rtl/dualmem_pkg.sv | 27 ++
 rtl/dualmem_clear.sv | 60 ++++++
 rtl/dualmem_be.sv | 155 +++++++++++++++
 tb/tb_dualmem_be.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dualmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dualmem_pkg
// Purpose  : Shared constants, clear-sequencer state type and byte-count
//            helper for the dualmem_be byte-write dual-port RAM.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package dualmem_pkg;

  // Same-port read-during-write selection values for RDW_MODE
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Post-reset zero-fill sequencer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Number of byte lanes in a word
  function automatic int bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dualmem_clear.sv
`default_nettype none
// ============================================================================
// Module   : dualmem_clear
// Purpose  : Post-reset zero-fill sequencer. Sweeps every word address once,
//            one per cycle, and flags the RAM busy while doing so.
// Ports    : clk      - clock
//            rst      - synchronous active-high reset; (re)starts the sweep
//            busy     - high during reset cycle and the whole sweep
//            clr_we   - write strobe for the zero fill
//            clr_addr - address being zeroed this cycle
// Revision : 1.0  initial release
// ============================================================================
module dualmem_clear
  import dualmem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_t            state;
  clr_state_t            state_next;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (state == CLEAR) begin
      // Counter wraps back to 0 on the last address, ready for the next sweep
      count_next = count + 1'b1;
      if (count == '1) begin
        state_next = IDLE;
      end
    end
  end

  // The reset cycle itself already reports busy so no access slips through,
  // but it must not write: array contents are not touched by rst alone.
  assign busy     = (state == CLEAR) || (rst && (CLEAR_ON_RESET != 0));
  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_addr = count;

endmodule
`default_nettype wire

// File: rtl/dualmem_be.sv
`default_nettype none
// ============================================================================
// Module   : dualmem_be
// Purpose  : Single-clock true dual-port RAM with per-byte write enables,
//            selectable same-port read-during-write, optional output
//            register and a post-reset zero-fill sweep.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            ena/enb                  - port access enables
//            wea/web                  - per-byte write enables
//            addra/addrb              - word addresses
//            dina/dinb                - write data
//            douta/doutb              - read data (latency 1 + OUT_REG)
//            busy                     - clear sweep running; accesses dropped
//            collision                - pulse: both ports wrote a common byte
// Revision : 1.0  initial release
// ============================================================================
module dualmem_be
  import dualmem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 11,
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [DATA_WIDTH/8-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]   addra,
  input  logic [DATA_WIDTH-1:0]   dina,
  output logic [DATA_WIDTH-1:0]   douta,
  input  logic                    enb,
  input  logic [DATA_WIDTH/8-1:0] web,
  input  logic [ADDR_WIDTH-1:0]   addrb,
  input  logic [DATA_WIDTH-1:0]   dinb,
  output logic [DATA_WIDTH-1:0]   doutb,
  output logic                    busy,
  output logic                    collision
);

  localparam int NB    = bytes(DATA_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  dualmem_clear #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Port A write path is borrowed by the sweep while busy
  logic [NB-1:0]         a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic [NB-1:0]         b_we;
  logic [NB-1:0]         b_keep;
  logic                  a_rd;
  logic                  b_rd;
  logic                  same_addr;

  always_comb begin
    if (busy) begin
      a_we   = {NB{clr_we}};
      a_addr = clr_addr;
      a_din  = '0;
    end else begin
      a_we   = ena ? wea : '0;
      a_addr = addra;
      a_din  = dina;
    end
  end

  assign b_we      = (enb && !busy) ? web : '0;
  assign a_rd      = ena && !busy;
  assign b_rd      = enb && !busy;
  assign same_addr = (a_addr == addrb);

  logic [DATA_WIDTH-1:0] old_a;
  logic [DATA_WIDTH-1:0] old_b;
  logic [DATA_WIDTH-1:0] wf_a;
  logic [DATA_WIDTH-1:0] wf_b;

  assign old_a = mem[addra];
  assign old_b = mem[addrb];

  // Per-byte merge: port B drops bytes that port A also writes at the same
  // address; write-first read words overlay each port's own bytes only, so
  // the other port's simultaneous write stays invisible to it.
  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign b_keep[i]          = b_we[i] && !(a_we[i] && same_addr);
    assign wf_a[8*i +: 8]     = a_we[i] ? a_din[8*i +: 8] : old_a[8*i +: 8];
    assign wf_b[8*i +: 8]     = b_we[i] ? dinb[8*i +: 8]  : old_b[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (b_keep[k]) begin
        mem[addrb][8*k +: 8] <= dinb[8*k +: 8];
      end
      if (a_we[k]) begin
        mem[a_addr][8*k +: 8] <= a_din[8*k +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_a      <= '0;
      rd_b      <= '0;
      collision <= 1'b0;
    end else begin
      if (a_rd) begin
        rd_a <= (RDW_MODE == RDW_WRITE_FIRST) ? wf_a : old_a;
      end
      if (b_rd) begin
        rd_b <= (RDW_MODE == RDW_WRITE_FIRST) ? wf_b : old_b;
      end
      collision <= a_rd && b_rd && same_addr && (|(a_we & b_we));
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;
    always_ff @(posedge clk) begin
      if (rst) begin
        q_a <= '0;
        q_b <= '0;
      end else begin
        q_a <= rd_a;
        q_b <= rd_b;
      end
    end
    assign douta = q_a;
    assign doutb = q_b;
  end else begin : g_no_out_reg
    assign douta = rd_a;
    assign doutb = rd_b;
  end

endmodule
`default_nettype wire

// File: tb/tb_dualmem_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_dualmem_be
// Purpose  : Scoreboard bench for dualmem_be. Two instances share stimulus:
//            d0 = OUT_REG 1 / read-first, d1 = OUT_REG 0 / write-first.
//            Expected values come from a word-array model of the memory.
// Revision : 1.0  initial release
// ============================================================================
module tb_dualmem_be;
  import dualmem_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          ena   = 1'b0;
  logic          enb   = 1'b0;
  logic [NB-1:0] wea   = '0;
  logic [NB-1:0] web   = '0;
  logic [AW-1:0] addra = '0;
  logic [AW-1:0] addrb = '0;
  logic [DW-1:0] dina  = '0;
  logic [DW-1:0] dinb  = '0;

  logic [DW-1:0] douta0, doutb0, douta1, doutb1;
  logic          busy0, busy1, coll0, coll1;

  dualmem_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1),
    .RDW_MODE(RDW_READ_FIRST), .CLEAR_ON_RESET(1)
  ) u_d0 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0),
    .busy(busy0), .collision(coll0)
  );

  dualmem_be #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0),
    .RDW_MODE(RDW_WRITE_FIRST), .CLEAR_ON_RESET(1)
  ) u_d1 (
    .clk(clk), .rst(rst),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta1),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1),
    .busy(busy1), .collision(coll1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] val;
  } item_t;

  // channels: 0 d0.douta, 1 d0.doutb, 2 d1.douta, 3 d1.doutb,
  //           4 d0.busy, 5 d1.busy, 6 d0.collision, 7 d1.collision
  item_t         sbq [8][$];
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] last [4];
  int            clear_left = 0;
  int            clr_ptr    = 0;
  int            checks     = 0;
  int            failures   = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] din,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  task automatic push(input int ch, input int due, input logic [DW-1:0] v);
    item_t it;
    it.due = due;
    it.val = v;
    sbq[ch].push_back(it);
  endtask

  // One cycle of stimulus; the model predicts every output it affects.
  task automatic drive(input logic r,
                       input logic ea, input logic [NB-1:0] wa,
                       input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, input logic [NB-1:0] wb,
                       input logic [AW-1:0] ab, input logic [DW-1:0] db);
    int            now;
    logic          coll;
    logic [DW-1:0] olda, oldb;
    @(posedge clk);
    #1;
    now = cyc;
    rst = r; ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    if (r) begin
      for (int ch = 0; ch < 8; ch++)
        while (sbq[ch].size() > 0 && sbq[ch][sbq[ch].size()-1].due > now)
          void'(sbq[ch].pop_back());
      for (int p = 0; p < 4; p++) last[p] = '0;
      clear_left = DEPTH;
      clr_ptr    = 0;
      push(4, now, 1); push(5, now, 1);
      push(6, now + 1, 0); push(7, now + 1, 0);
      push(0, now + 1, 0); push(1, now + 1, 0);
      push(0, now + 2, 0); push(1, now + 2, 0);
      push(2, now + 1, 0); push(3, now + 1, 0);
    end else begin
      coll = 1'b0;
      push(4, now, DW'(clear_left > 0)); push(5, now, DW'(clear_left > 0));
      if (clear_left > 0) begin
        mdl_mem[clr_ptr] = '0;
        clr_ptr++;
        clear_left--;
      end else begin
        olda = mdl_mem[aa];
        oldb = mdl_mem[ab];
        if (ea) begin last[0] = olda; last[2] = merge(olda, da, wa); end
        if (eb) begin last[1] = oldb; last[3] = merge(oldb, db, wb); end
        coll = ea && eb && (aa == ab) && ((wa & wb) != '0);
        if (eb) mdl_mem[ab] = merge(mdl_mem[ab], db, wb);
        if (ea) mdl_mem[aa] = merge(mdl_mem[aa], da, wa);  // A wins shared bytes
      end
      push(6, now + 1, DW'(coll)); push(7, now + 1, DW'(coll));
      push(0, now + 2, last[0]); push(1, now + 2, last[1]);
      push(2, now + 1, last[2]); push(3, now + 1, last[3]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, '0, 0, '0, '0, '0);
  endtask

  task automatic rd2(input logic [AW-1:0] aa, input logic [AW-1:0] ab);
    drive(0, 1, '0, aa, '0, 1, '0, ab, '0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [DW-1:0] act;
    item_t         it;
    string         nm;
    for (int ch = 0; ch < 8; ch++) begin
      case (ch)
        0: begin act = douta0;        nm = "d0_douta"; end
        1: begin act = doutb0;        nm = "d0_doutb"; end
        2: begin act = douta1;        nm = "d1_douta"; end
        3: begin act = doutb1;        nm = "d1_doutb"; end
        4: begin act = DW'(busy0);    nm = "d0_busy"; end
        5: begin act = DW'(busy1);    nm = "d1_busy"; end
        6: begin act = DW'(coll0);    nm = "d0_collision"; end
        default: begin act = DW'(coll1); nm = "d1_collision"; end
      endcase
      while (sbq[ch].size() > 0 && sbq[ch][0].due < cyc) begin
        it = sbq[ch].pop_front();
        checks++;
        failures++;
        $display("FAIL %s missed slot due=%0d at cyc=%0d", nm, it.due, cyc);
      end
      if (sbq[ch].size() > 0 && sbq[ch][0].due == cyc) begin
        it = sbq[ch].pop_front();
        checks++;
        if (act !== it.val) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, it.val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    for (int p = 0; p < 4; p++) last[p] = '0;

    // Initial reset and sweep
    drive(1, 0, '0, '0, '0, 0, '0, '0, '0);
    idle(DEPTH + 2);

    // Preload 0xDEADBEEF everywhere, check a few, then reset sweep with
    // reads attempted throughout (they must be dropped, outputs stay 0)
    for (int a = 0; a < DEPTH; a += 2)
      drive(0, 1, '1, AW'(a), 32'hDEADBEEF, 1, '1, AW'(a + 1), 32'hDEADBEEF);
    rd2(0, 15);
    drive(1, 1, '0, 4'd1, '0, 1, '0, 4'd2, '0);
    for (int i = 0; i < DEPTH; i++) rd2(AW'(i), AW'(DEPTH - 1 - i));
    for (int i = 0; i < DEPTH; i++) rd2(AW'(i), AW'(DEPTH - 1 - i));

    // Byte enables
    drive(0, 1, 4'hF, 4'd3, 32'h11223344, 0, '0, '0, '0);
    drive(0, 1, 4'b0101, 4'd3, 32'hAABBCCDD, 0, '0, '0, '0);
    rd2(3, 3);
    idle(2);

    // Read-during-write, same port and cross port
    drive(0, 1, 4'hF, 4'd5, 32'h1, 0, '0, '0, '0);
    drive(0, 1, 4'hF, 4'd5, 32'h2, 1, '0, 4'd5, '0);
    rd2(5, 5);

    // Write-write collision with overlapping byte 1
    drive(0, 1, 4'b0011, 4'd7, 32'hAAAAAAAA, 1, 4'b0110, 4'd7, 32'hBBBBBBBB);
    rd2(7, 7);
    idle(2);

    // Reset mid-sweep; an access at sweep cycle 12 is dropped
    drive(0, 1, 4'hF, 4'd2, 32'h5A5A5A5A, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0, 0, '0, '0, '0);
    idle(8);
    drive(1, 0, '0, '0, '0, 0, '0, '0, '0);
    idle(11);
    drive(0, 1, 4'hF, 4'd2, 32'h12345678, 1, 4'hF, 4'd9, 32'h87654321);
    idle(5);
    rd2(2, 9);
    idle(2);

    // Random back-to-back traffic on both ports
    for (int i = 0; i < 10000; i++)
      drive(0, ($urandom_range(3) != 0), NB'($urandom), AW'($urandom), $urandom,
               ($urandom_range(3) != 0), NB'($urandom), AW'($urandom), $urandom);
    idle(3);

    // Let every predicted slot come due, then nothing may be left over
    repeat (4) @(negedge clk);
    #1;
    for (int ch = 0; ch < 8; ch++) begin
      checks++;
      if (sbq[ch].size() != 0) begin
        failures++;
        $display("FAIL leftover ch%0d actual=%0d pending required=0", ch, sbq[ch].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
